// File: rtl/gelu_arbiter.sv
// Two-requester burst arbiter feeding a piecewise-linear GELU stage (signed Q3.5 in and out).
// Optional per-requester accepted-beat counters (cnt0/cnt1) are built when GELU_ARB_PERF_CNT_EN is defined.
module gelu_arbiter #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s0_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  input  logic [7:0] s1_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_src,
  output logic       busy
`ifdef GELU_ARB_PERF_CNT_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] burst_cnt_q;
  logic       last_served_q;
  logic       m_valid_q;
  logic [7:0] m_data_q;
  logic       m_src_q;

  logic       stage_free_s;
  logic       xfer0_s;
  logic       xfer1_s;
  logic       xfer_s;
  logic       burst_end_s;
  logic       cur_s;
  logic       cur_valid_s;
  logic       oth_valid_s;
  state_t     oth_state_s;
  logic [7:0] m_data_d;

  // Sign-extend to 9 bits so the offsets and arithmetic shifts cannot overflow.
  function automatic logic [7:0] gelu_f(input logic [7:0] x_raw);
    logic signed [7:0] x;
    logic signed [8:0] xe;
    logic signed [8:0] y;
    x  = x_raw;
    xe = x;
    if (x <= -8'sd80) begin
      y = 9'sd0;
    end else if (x < -8'sd16) begin
      y = -9'sd1 - ((xe + 9'sd80) >>> 4);
    end else if (x < 8'sd0) begin
      y = ((xe + 9'sd16) >>> 2) - 9'sd5;
    end else begin
      y = xe;
    end
    return y[7:0];
  endfunction

  assign stage_free_s = !m_valid_q || m_ready;
  assign s0_ready     = (state_q == SERVE0) && stage_free_s;
  assign s1_ready     = (state_q == SERVE1) && stage_free_s;
  assign xfer0_s      = s0_valid && s0_ready;
  assign xfer1_s      = s1_valid && s1_ready;
  assign xfer_s       = xfer0_s || xfer1_s;
  assign burst_end_s  = (burst_cnt_q == 4'(BURST_LEN - 1));
  assign cur_s        = (state_q == SERVE1);
  assign cur_valid_s  = cur_s ? s1_valid : s0_valid;
  assign oth_valid_s  = cur_s ? s0_valid : s1_valid;
  assign oth_state_s  = cur_s ? SERVE0 : SERVE1;
  assign m_data_d     = gelu_f(xfer1_s ? s1_data : s0_data);

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_src   = m_src_q;
  assign busy    = (state_q != IDLE) || m_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      burst_cnt_q   <= 4'd0;
      last_served_q <= 1'b1;
      m_valid_q     <= 1'b0;
      m_data_q      <= 8'd0;
      m_src_q       <= 1'b0;
    end else begin
      if (xfer_s) begin
        m_valid_q <= 1'b1;
        m_data_q  <= m_data_d;
        m_src_q   <= xfer1_s;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          burst_cnt_q <= 4'd0;
          if (s0_valid && s1_valid) begin
            state_q <= last_served_q ? SERVE0 : SERVE1;
          end else if (s0_valid) begin
            state_q <= SERVE0;
          end else if (s1_valid) begin
            state_q <= SERVE1;
          end else begin
            state_q <= IDLE;
          end
        end
        SERVE0, SERVE1: begin
          if (!cur_valid_s) begin
            burst_cnt_q   <= 4'd0;
            last_served_q <= cur_s;
            state_q       <= oth_valid_s ? oth_state_s : IDLE;
          end else if (xfer_s) begin
            if (burst_end_s) begin
              // Burst exhausted: hand over only if the other side is waiting.
              burst_cnt_q <= 4'd0;
              if (oth_valid_s) begin
                last_served_q <= cur_s;
                state_q       <= oth_state_s;
              end
            end else begin
              burst_cnt_q <= burst_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          burst_cnt_q <= 4'd0;
        end
      endcase
    end
  end

`ifdef GELU_ARB_PERF_CNT_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      if (xfer0_s) cnt0_q <= cnt0_q + 16'd1;
      if (xfer1_s) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
